// File: rtl/exp_ctrl_if.sv
// Control/status bundle between exp_ctrl_fsm, its start/ready requester and the
// series-expansion datapath. master = controller side, slave = requester/datapath side.
interface exp_ctrl_if;
  logic start;
  logic mode_in;
  logic done;
  logic gt;
  logic ready;
  logic out_valid;
  logic counter_en;
  logic sel_1;
  logic sel_2;
  logic sel_x;
  logic sel_t;
  logic load_x;
  logic load_m;
  logic load_t;
  logic mode;
  logic abort;

  modport master (
    input  start, mode_in, done, gt,
    output ready, out_valid, counter_en, sel_1, sel_2, sel_x, sel_t,
           load_x, load_m, load_t, mode, abort
  );

  modport slave (
    output start, mode_in, done, gt,
    input  ready, out_valid, counter_en, sel_1, sel_2, sel_x, sel_t,
           load_x, load_m, load_t, mode, abort
  );
endinterface

// File: rtl/exp_ctrl_fsm.sv
// Moore controller for the series-expansion datapath: load X, init T, then
// MULX/MULC/ACC per term until done, !gt or MAX_TERMS. Optional watchdog: EXP_CTRL_WDOG_EN.
module exp_ctrl_fsm #(
  parameter int MAX_TERMS   = 8,
  parameter int WDOG_CYCLES = 64
) (
  input logic        clk,
  input logic        rst,
  exp_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_MULX,
    S_MULC,
    S_ACC,
    S_FIN
  } state_t;

  localparam int                ITER_W   = $clog2(MAX_TERMS + 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_TERMS);

  state_t            state;
  state_t            state_nxt;
  logic [ITER_W-1:0] iter_cnt;
  logic              mode_q;
  logic              accept;
  logic              last_term;
  logic              wdog_hit;

  assign accept    = (state == S_IDLE) && bus.start;
  assign last_term = (iter_cnt >= ITER_MAX - 1'b1);

`ifdef EXP_CTRL_WDOG_EN
  localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Counts non-IDLE cycles of the current run; hit flags the WDOG_CYCLES-th one.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
    end else if (accept) begin
      wdog_cnt <= '0;
    end else if (state != S_IDLE && wdog_cnt != WDOG_LAST) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wdog_hit = (state != S_IDLE) && (wdog_cnt == WDOG_LAST);
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES > 0);
  assign wdog_hit    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      mode_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q <= bus.mode_in;
      end
      if (state == S_INIT) begin
        iter_cnt <= '0;
      end else if (state == S_ACC && iter_cnt != ITER_MAX) begin
        iter_cnt <= iter_cnt + 1'b1;
      end
    end
  end

  // NOTE: every output and next-state gets a default before the case, so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    bus.ready      = 1'b0;
    bus.out_valid  = 1'b0;
    bus.counter_en = 1'b0;
    bus.sel_1      = 1'b0;
    bus.sel_2      = 1'b0;
    bus.sel_x      = 1'b0;
    bus.sel_t      = 1'b0;
    bus.load_x     = 1'b0;
    bus.load_m     = 1'b0;
    bus.load_t     = 1'b0;

    unique case (state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.load_x = 1'b1;
        state_nxt  = S_INIT;
      end
      S_INIT: begin
        bus.load_t = 1'b1;
        state_nxt  = S_MULX;
      end
      S_MULX: begin
        bus.sel_1  = 1'b1;
        bus.load_m = 1'b1;
        state_nxt  = S_MULC;
      end
      S_MULC: begin
        bus.sel_1  = 1'b1;
        bus.sel_2  = 1'b1;
        bus.load_t = 1'b1;
        bus.sel_t  = 1'b1;
        state_nxt  = S_ACC;
      end
      S_ACC: begin
        bus.counter_en = 1'b1;
        if (bus.done || !bus.gt || last_term) begin
          state_nxt = S_FIN;
        end else begin
          state_nxt = S_MULX;
        end
      end
      S_FIN: begin
        bus.out_valid = !wdog_hit;
        state_nxt     = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Watchdog overrides whatever the sequence wanted this cycle.
    if (wdog_hit) begin
      state_nxt = S_IDLE;
    end
  end

  assign bus.mode  = mode_q;
  assign bus.abort = wdog_hit;

endmodule

// File: tb/tb_exp_ctrl_fsm.sv
// Self-checking bench for exp_ctrl_fsm: directed latency scenarios plus random runs,
// compared cycle by cycle against a run-position reference model.
module tb_exp_ctrl_fsm;

  localparam int MAX_T   = 8;
  localparam int WD      = 10;
  localparam int LEN_MAX = 64;
`ifdef EXP_CTRL_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  // {ready,out_valid,counter_en,sel_1,sel_2,sel_x,sel_t,load_x,load_m,load_t,mode,abort}
  localparam int B_READY = 11, B_OV = 10, B_CEN = 9, B_SEL_T = 5;
  localparam int B_LX = 4, B_LM = 3, B_LT = 2, B_MODE = 1, B_ABORT = 0;
  localparam logic [11:0] RESET_VEC = 12'b1000_0000_0000;

  logic clk = 1'b0;
  logic rst;

  exp_ctrl_if bus ();

  exp_ctrl_fsm #(.MAX_TERMS(MAX_T), .WDOG_CYCLES(WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_test;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus schedule indexed by cycle offset within a run.
  bit          start_s [LEN_MAX];
  bit          done_s  [LEN_MAX];
  bit          gt_s    [LEN_MAX];
  bit          mode_s  [LEN_MAX];
  bit          rst_s   [LEN_MAX];
  logic [11:0] obs     [LEN_MAX];

  // Reference model: position within the current run (1 = first busy cycle).
  bit m_busy = 1'b0;
  int m_pos  = 0;
  int m_fin  = 0;
  bit m_mode = 1'b0;

  function automatic logic [11:0] model_vec();
    logic [11:0] v;
    bit          ab;
    v         = '0;
    v[B_MODE] = m_mode;
    if (!m_busy) begin
      v[B_READY] = 1'b1;
    end else begin
      ab         = WD_EN && (m_pos == WD);
      v[B_ABORT] = ab;
      if (m_pos == 1) begin
        v[B_LX] = 1'b1;
      end else if (m_pos == 2) begin
        v[B_LT] = 1'b1;
      end else if (m_fin != 0 && m_pos == m_fin) begin
        v[B_OV] = !ab;
      end else begin
        case ((m_pos - 3) % 3)
          0:       begin v[8] = 1'b1; v[B_LM] = 1'b1; end
          1:       begin v[8] = 1'b1; v[7] = 1'b1; v[B_LT] = 1'b1; v[B_SEL_T] = 1'b1; end
          default: v[B_CEN] = 1'b1;
        endcase
      end
    end
    return v;
  endfunction

  task automatic model_step(input bit s, input bit d, input bit g, input bit mi, input bit r);
    int term;
    if (r) begin
      m_busy = 1'b0; m_pos = 0; m_fin = 0; m_mode = 1'b0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1'b1; m_pos = 1; m_fin = 0; m_mode = mi;
      end
    end else if (WD_EN && m_pos == WD) begin
      m_busy = 1'b0;
    end else if (m_fin != 0 && m_pos == m_fin) begin
      m_busy = 1'b0;
    end else begin
      if (m_pos >= 3 && (m_pos - 3) % 3 == 2) begin
        term = (m_pos - 3) / 3 + 1;
        if (d || !g || term >= MAX_T) m_fin = m_pos + 1;
      end
      m_pos++;
    end
  endtask

  function automatic logic [11:0] dut_vec();
    return {bus.ready, bus.out_valid, bus.counter_en, bus.sel_1, bus.sel_2, bus.sel_x,
            bus.sel_t, bus.load_x, bus.load_m, bus.load_t, bus.mode, bus.abort};
  endfunction

  function automatic int exp_ov(input int n_terms);
    int f;
    f = 3 + 3 * n_terms;
    return (WD_EN && f >= WD) ? -1 : f;
  endfunction

  function automatic int count_bit(input int b, input int len);
    int c = 0;
    for (int i = 0; i < len; i++) if (obs[i][b]) c++;
    return c;
  endfunction

  function automatic int first_bit(input int b, input int len);
    for (int i = 0; i < len; i++) if (obs[i][b]) return i;
    return -1;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < LEN_MAX; i++) begin
      start_s[i] = 1'b0; done_s[i] = 1'b0; gt_s[i] = 1'b1; mode_s[i] = 1'b0; rst_s[i] = 1'b0;
    end
  endtask

  task automatic run(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      obs[i] = dut_vec();
      check($sformatf("%s/outs@%0d", cur_test, i), obs[i], model_vec());
      rst         = rst_s[i];
      bus.start   = start_s[i];
      bus.done    = done_s[i];
      bus.gt      = gt_s[i];
      bus.mode_in = mode_s[i];
      model_step(start_s[i], done_s[i], gt_s[i], mode_s[i], rst_s[i]);
    end
  endtask

  task automatic reset_run();
    clear_sched();
    rst_s[0] = 1'b1;
    run(1);
    clear_sched();
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.done = 1'b0; bus.gt = 1'b1; bus.mode_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", dut_vec(), RESET_VEC);

    cur_test = "three_terms";
    reset_run();
    start_s[0] = 1'b1; done_s[11] = 1'b1;
    run(16);
    check("three_terms_ov_at", first_bit(B_OV, 16), exp_ov(3));
`ifndef EXP_CTRL_WDOG_EN
    check("three_terms_ov_cnt", count_bit(B_OV, 16), 1);
    check("three_terms_cen_cnt", count_bit(B_CEN, 16), 3);
`endif

    cur_test = "gt0_first";
    reset_run();
    start_s[0] = 1'b1; gt_s[5] = 1'b0;
    run(10);
    check("gt0_ov_at", first_bit(B_OV, 10), 6);
    check("gt0_load_m_cnt", count_bit(B_LM, 10), 1);
    check("gt0_load_t_prod_cnt", count_bit(B_SEL_T, 10), 1);

    cur_test = "done_and_gt0";
    reset_run();
    start_s[0] = 1'b1; done_s[5] = 1'b1; gt_s[5] = 1'b0;
    run(10);
    check("both_ov_cnt", count_bit(B_OV, 10), 1);
    check("both_ov_at", first_bit(B_OV, 10), 6);

    cur_test = "max_terms";
    reset_run();
    start_s[0] = 1'b1;
    run(32);
    check("max_ov_at", first_bit(B_OV, 32), exp_ov(MAX_T));
`ifdef EXP_CTRL_WDOG_EN
    check("wdog_abort_at", first_bit(B_ABORT, 32), 10);
    check("wdog_abort_cnt", count_bit(B_ABORT, 32), 1);
    check("wdog_ready_after", obs[11][B_READY], 1'b1);
`else
    check("max_cen_cnt", count_bit(B_CEN, 32), MAX_T);
    check("max_abort_cnt", count_bit(B_ABORT, 32), 0);
`endif

    cur_test = "rst_midrun";
    reset_run();
    start_s[0] = 1'b1; mode_s[0] = 1'b1; start_s[2] = 1'b1; rst_s[4] = 1'b1;
    run(10);
    check("rst_ov_cnt", count_bit(B_OV, 10), 0);
    check("rst_ready_next", obs[5][B_READY], 1'b1);
    check("rst_mode_held", obs[3][B_MODE], 1'b1);
    check("rst_busy_start_ignored", count_bit(B_LX, 10), 1);

    cur_test = "back_to_back";
    reset_run();
    for (int i = 0; i < 16; i++) start_s[i] = 1'b1;
    gt_s[5] = 1'b0; gt_s[12] = 1'b0;
    run(16);
    check("b2b_ready_after_fin", obs[7][B_READY], 1'b1);
    check("b2b_reload", obs[8][B_LX], 1'b1);
    check("b2b_ov_cnt", count_bit(B_OV, 16), 2);

    cur_test = "random";
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 40; i++) begin
        start_s[i] = ($urandom_range(3) == 0);
        done_s[i]  = ($urandom_range(9) == 0);
        gt_s[i]    = ($urandom_range(9) != 0);
        mode_s[i]  = $urandom_range(1) != 0;
        rst_s[i]   = ($urandom_range(59) == 0);
      end
      run(40);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
